change_dispenser: RTL and testbench

//   Pays out the change amount the vending controller reports, one coin at a time.

---
 rtl/vend_pkg.sv | 30 +++
 rtl/coin_selector.sv | 37 +++
 rtl/change_dispenser.sv | 191 +++++++++++++++++++
 tb/tb_change_dispenser.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending definitions: coin codes, denomination values, error codes, FSM states.
package vend_pkg;

  // Coin codes as seen on the hopper and coin-acceptor interfaces.
  typedef enum logic [1:0] {
    CoinNone = 2'b00,
    Coin5    = 2'b01,
    Coin10   = 2'b10,
    Coin20   = 2'b11
  } coin_e;

  typedef enum logic [1:0] {
    ErrNone         = 2'b00,
    ErrBadAmt       = 2'b01,
    ErrInsufficient = 2'b10,
    ErrJam          = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StSelect = 2'b01,
    StIssue  = 2'b10,
    StDone   = 2'b11
  } state_e;

  localparam int unsigned Val5  = 5;
  localparam int unsigned Val10 = 10;
  localparam int unsigned Val20 = 20;

endpackage

// File: rtl/coin_selector.sv
// Greedy coin pick: largest denomination that fits the amount owed and is in stock.
module coin_selector
  import vend_pkg::*;
#(
  parameter int unsigned AMT_W = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic [AMT_W-1:0] remaining_i,
  input  logic [CNT_W-1:0] inv20_i,
  input  logic [CNT_W-1:0] inv10_i,
  input  logic [CNT_W-1:0] inv5_i,
  output coin_e            coin_o,
  output logic [AMT_W-1:0] value_o,
  output logic             found_o
);

  // Priority order 20 > 10 > 5; an empty tube falls through to the next size.
  always_comb begin
    coin_o  = CoinNone;
    value_o = '0;
    found_o = 1'b0;
    if (remaining_i >= AMT_W'(Val20) && inv20_i != '0) begin
      coin_o  = Coin20;
      value_o = AMT_W'(Val20);
      found_o = 1'b1;
    end else if (remaining_i >= AMT_W'(Val10) && inv10_i != '0) begin
      coin_o  = Coin10;
      value_o = AMT_W'(Val10);
      found_o = 1'b1;
    end else if (remaining_i >= AMT_W'(Val5) && inv5_i != '0) begin
      coin_o  = Coin5;
      value_o = AMT_W'(Val5);
      found_o = 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays the requested amount one coin at a time from tracked inventory.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned AMT_W       = 8,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned MAX_AMT     = 99,
  parameter int unsigned INIT_20     = 10,
  parameter int unsigned INIT_10     = 10,
  parameter int unsigned INIT_5      = 20,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             change_valid,
  input  logic [AMT_W-1:0] change_amt,
  output logic             change_ready,
  input  logic             refill,
  output logic [1:0]       coin_out,
  output logic             coin_valid,
  input  logic             coin_ack,
  output logic [AMT_W-1:0] remaining,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [2:0]       low_stock
);

  // Counter only needs to hold 0 .. ACK_TIMEOUT-1.
  localparam int unsigned TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TmrLast = TMR_W'(ACK_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] inv20_q, inv20_d;
  logic [CNT_W-1:0] inv10_q, inv10_d;
  logic [CNT_W-1:0] inv5_q, inv5_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  coin_e            coin_q, coin_d;
  logic [AMT_W-1:0] coin_val_q, coin_val_d;
  logic             error_q, error_d;
  err_e             err_code_q, err_code_d;

  coin_e            sel_coin;
  logic [AMT_W-1:0] sel_value;
  logic             sel_found;
  logic [AMT_W-1:0] rem_after;
  logic             amt_bad;

  coin_selector #(
    .AMT_W (AMT_W),
    .CNT_W (CNT_W)
  ) u_coin_selector (
    .remaining_i (remaining_q),
    .inv20_i     (inv20_q),
    .inv10_i     (inv10_q),
    .inv5_i      (inv5_q),
    .coin_o      (sel_coin),
    .value_o     (sel_value),
    .found_o     (sel_found)
  );

  // Request validation and post-payment remainder.
  always_comb begin
    amt_bad   = (change_amt > AMT_W'(MAX_AMT)) || ((change_amt % AMT_W'(Val5)) != '0);
    rem_after = remaining_q - coin_val_q;
  end

  // Next-state logic for the FSM, remaining amount, inventory and ack timer.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    inv20_d     = inv20_q;
    inv10_d     = inv10_q;
    inv5_d      = inv5_q;
    tmr_d       = tmr_q;
    coin_d      = coin_q;
    coin_val_d  = coin_val_q;
    error_d     = error_q;
    err_code_d  = err_code_q;

    unique case (state_q)
      StIdle: begin
        // Refill lands at the same edge as an accept, so SELECT sees the new counts.
        if (refill) begin
          inv20_d = CNT_W'(INIT_20);
          inv10_d = CNT_W'(INIT_10);
          inv5_d  = CNT_W'(INIT_5);
        end
        if (change_valid) begin
          error_d    = 1'b0;
          err_code_d = ErrNone;
          if (change_amt == '0) begin
            remaining_d = '0;
            state_d     = StDone;
          end else if (amt_bad) begin
            remaining_d = '0;
            error_d     = 1'b1;
            err_code_d  = ErrBadAmt;
          end else begin
            remaining_d = change_amt;
            state_d     = StSelect;
          end
        end
      end

      StSelect: begin
        if (sel_found) begin
          coin_d     = sel_coin;
          coin_val_d = sel_value;
          tmr_d      = '0;
          state_d    = StIssue;
        end else begin
          error_d    = 1'b1;
          err_code_d = ErrInsufficient;
          state_d    = StIdle;
        end
      end

      StIssue: begin
        // An ack on the final timeout cycle still counts as a paid coin.
        if (coin_ack) begin
          remaining_d = rem_after;
          unique case (coin_q)
            Coin20:  if (inv20_q != '0) inv20_d = inv20_q - CNT_W'(1);
            Coin10:  if (inv10_q != '0) inv10_d = inv10_q - CNT_W'(1);
            Coin5:   if (inv5_q != '0) inv5_d = inv5_q - CNT_W'(1);
            default: ;
          endcase
          state_d = (rem_after == '0) ? StDone : StSelect;
        end else if (tmr_q == TmrLast) begin
          error_d    = 1'b1;
          err_code_d = ErrJam;
          state_d    = StIdle;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset; inventories reload to their initial fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      inv20_q     <= CNT_W'(INIT_20);
      inv10_q     <= CNT_W'(INIT_10);
      inv5_q      <= CNT_W'(INIT_5);
      tmr_q       <= '0;
      coin_q      <= CoinNone;
      coin_val_q  <= '0;
      error_q     <= 1'b0;
      err_code_q  <= ErrNone;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      inv20_q     <= inv20_d;
      inv10_q     <= inv10_d;
      inv5_q      <= inv5_d;
      tmr_q       <= tmr_d;
      coin_q      <= coin_d;
      coin_val_q  <= coin_val_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
    end
  end

  // Outputs decoded from state; coin_out is held stable for the whole ISSUE phase.
  always_comb begin
    change_ready = (state_q == StIdle);
    busy         = (state_q != StIdle);
    done         = (state_q == StDone);
    coin_valid   = (state_q == StIssue);
    coin_out     = (state_q == StIssue) ? coin_q : CoinNone;
    remaining    = remaining_q;
    error        = error_q;
    err_code     = err_code_q;
    low_stock    = {inv20_q == '0, inv10_q == '0, inv5_q == '0};
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: three parameterisations share stimulus, one is observed at a time.
module tb_change_dispenser;

  localparam int AckTimeout = 255;

  typedef struct {
    int         sel;
    bit         rst;
    int         amt;
    int         dly;
    int         n;
    logic [1:0] c[6];
    int         err;
    int         rem;
    int         dn;
    logic [2:0] low;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       change_valid;
  logic [7:0] change_amt;
  logic       refill;
  logic       coin_ack;

  logic       ready_w[3];
  logic [1:0] coin_out_w[3];
  logic       coin_valid_w[3];
  logic [7:0] remaining_w[3];
  logic       busy_w[3];
  logic       done_w[3];
  logic       error_w[3];
  logic [1:0] err_code_w[3];
  logic [2:0] low_w[3];

  logic       s_ready, s_coin_valid, s_busy, s_done, s_error;
  logic [1:0] s_coin_out, s_err_code;
  logic [7:0] s_rem;
  logic [2:0] s_low;

  int         sel;
  int         n_checks;
  int         n_errors;
  int         done_cnt;
  bit         ack_en;
  int         ack_dly;
  int         k;
  logic [1:0] exp_q[$];
  vec_t       vecs[$];

  always #5 clk = ~clk;

  change_dispenser u_a (
    .clk (clk), .reset (reset), .change_valid (change_valid), .change_amt (change_amt),
    .change_ready (ready_w[0]), .refill (refill), .coin_out (coin_out_w[0]),
    .coin_valid (coin_valid_w[0]), .coin_ack (coin_ack), .remaining (remaining_w[0]),
    .busy (busy_w[0]), .done (done_w[0]), .error (error_w[0]), .err_code (err_code_w[0]),
    .low_stock (low_w[0])
  );

  change_dispenser #(.INIT_20(1)) u_b (
    .clk (clk), .reset (reset), .change_valid (change_valid), .change_amt (change_amt),
    .change_ready (ready_w[1]), .refill (refill), .coin_out (coin_out_w[1]),
    .coin_valid (coin_valid_w[1]), .coin_ack (coin_ack), .remaining (remaining_w[1]),
    .busy (busy_w[1]), .done (done_w[1]), .error (error_w[1]), .err_code (err_code_w[1]),
    .low_stock (low_w[1])
  );

  change_dispenser #(.INIT_20(0), .INIT_10(0), .INIT_5(2)) u_c (
    .clk (clk), .reset (reset), .change_valid (change_valid), .change_amt (change_amt),
    .change_ready (ready_w[2]), .refill (refill), .coin_out (coin_out_w[2]),
    .coin_valid (coin_valid_w[2]), .coin_ack (coin_ack), .remaining (remaining_w[2]),
    .busy (busy_w[2]), .done (done_w[2]), .error (error_w[2]), .err_code (err_code_w[2]),
    .low_stock (low_w[2])
  );

  always_comb begin
    s_ready      = ready_w[sel];
    s_coin_out   = coin_out_w[sel];
    s_coin_valid = coin_valid_w[sel];
    s_rem        = remaining_w[sel];
    s_busy       = busy_w[sel];
    s_done       = done_w[sel];
    s_error      = error_w[sel];
    s_err_code   = err_code_w[sel];
    s_low        = low_w[sel];
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Hopper model: acks ack_dly cycles into each coin and scores the coin code.
  initial begin
    k = 0;
    forever begin
      @(negedge clk);
      if (ack_en) begin
        if (s_coin_valid) begin
          coin_ack = (k == ack_dly);
          if (coin_ack) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL unexpected coin: got code %0d expected no coin", s_coin_out);
            end else begin
              check("coin code", int'(s_coin_out), int'(exp_q.pop_front()));
            end
          end
          k++;
        end else begin
          coin_ack = 1'b0;
          k = 0;
        end
      end
    end
  end

  // Done-pulse counter.
  initial forever begin
    @(negedge clk);
    if (s_done) done_cnt++;
  end

  // Hard stop if anything wedges.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic add(input int vs, input bit rst, input int amt, input int dly, input int err,
                     input int rem, input int dn, input logic [2:0] low, input int c0 = 0,
                     input int c1 = 0, input int c2 = 0, input int c3 = 0, input int c4 = 0,
                     input int c5 = 0);
    vec_t v;
    int   cs[6];
    cs = '{c0, c1, c2, c3, c4, c5};
    v.sel = vs; v.rst = rst; v.amt = amt; v.dly = dly; v.err = err; v.rem = rem;
    v.dn = dn; v.low = low; v.n = 0;
    for (int i = 0; i < 6; i++) begin
      v.c[i] = 2'(cs[i]);
      if (cs[i] != 0) v.n++;
    end
    vecs.push_back(v);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive_req(input int amt, input bit rf);
    @(negedge clk);
    change_amt   = 8'(amt);
    change_valid = 1'b1;
    refill       = rf;
    @(negedge clk);
    change_valid = 1'b0;
    refill       = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int cyc = 0;
    while (s_busy && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " idle within bound"}, int'(s_busy), 0);
  endtask

  initial begin
    int   cyc;
    int   hi;
    vec_t v;
    reset = 1'b1; change_valid = 1'b0; change_amt = '0; refill = 1'b0; coin_ack = 1'b0;
    ack_en = 1'b0; ack_dly = 1; sel = 0; n_checks = 0; n_errors = 0; done_cnt = 0;

    // coin codes: 1 = 5, 2 = 10, 3 = 20
    add(0, 1, 25, 1, 0, 0, 1, 3'b000, 3, 1);
    add(0, 0, 0, 1, 0, 0, 1, 3'b000);
    add(0, 0, 17, 1, 1, 0, 0, 3'b000);
    add(0, 0, 120, 1, 1, 0, 0, 3'b000);
    add(0, 0, 100, 1, 1, 0, 0, 3'b000);
    add(0, 0, 95, 0, 0, 0, 1, 3'b000, 3, 3, 3, 3, 2, 1);
    add(0, 0, 35, 2, 0, 0, 1, 3'b000, 3, 2, 1);
    add(0, 0, 99, 1, 1, 0, 0, 3'b000);
    add(1, 1, 40, 1, 0, 0, 1, 3'b100, 3, 2, 2);
    add(1, 0, 20, 0, 0, 0, 1, 3'b100, 2, 2);
    add(2, 1, 30, 1, 2, 20, 0, 3'b111, 1, 1);
    add(2, 0, 5, 1, 2, 5, 0, 3'b111);
    add(2, 1, 10, 1, 0, 0, 1, 3'b111, 1, 1);

    repeat (3) @(negedge clk);
    check("reset ready", int'(s_ready), 1);
    check("reset coin_valid", int'(s_coin_valid), 0);
    check("reset coin_out", int'(s_coin_out), 0);
    check("reset busy", int'(s_busy), 0);
    check("reset done", int'(s_done), 0);
    check("reset error", int'(s_error), 0);
    check("reset err_code", int'(s_err_code), 0);
    check("reset remaining", int'(s_rem), 0);
    check("reset low_stock", int'(s_low), 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      v = vecs[i];
      sel = v.sel;
      if (v.rst) apply_reset();
      ack_dly = v.dly;
      ack_en = 1'b1;
      exp_q.delete();
      for (int j = 0; j < v.n; j++) exp_q.push_back(v.c[j]);
      done_cnt = 0;
      check($sformatf("v%0d ready", i), int'(s_ready), 1);
      drive_req(v.amt, 1'b0);
      wait_idle($sformatf("v%0d", i));
      check($sformatf("v%0d done pulses", i), done_cnt, v.dn);
      check($sformatf("v%0d err_code", i), int'(s_err_code), v.err);
      check($sformatf("v%0d error", i), int'(s_error), int'(v.err != 0));
      check($sformatf("v%0d remaining", i), int'(s_rem), v.rem);
      check($sformatf("v%0d low_stock", i), int'(s_low), int'(v.low));
      check($sformatf("v%0d coin_valid", i), int'(s_coin_valid), 0);
      check($sformatf("v%0d coins left", i), exp_q.size(), 0);
    end

    // Refill in the accept cycle feeds the empty 5-tube; a refill mid-payment is ignored.
    exp_q.delete();
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b01);
    done_cnt = 0;
    drive_req(10, 1'b1);
    @(negedge clk);
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    wait_idle("refill");
    check("refill done", done_cnt, 1);
    check("refill error", int'(s_error), 0);
    check("refill low_stock", int'(s_low), 3'b111);
    check("refill coins left", exp_q.size(), 0);

    // Hopper jam: no ack for the whole timeout window.
    sel = 0;
    apply_reset();
    ack_en = 1'b0;
    coin_ack = 1'b0;
    exp_q.delete();
    drive_req(10, 1'b0);
    hi = 0;
    cyc = 0;
    while (s_busy && cyc < 2000) begin
      if (s_coin_valid) hi++;
      @(negedge clk);
      cyc++;
    end
    check("jam issue cycles", hi, AckTimeout);
    check("jam err_code", int'(s_err_code), 3);
    check("jam error", int'(s_error), 1);
    check("jam coin_valid", int'(s_coin_valid), 0);
    check("jam remaining", int'(s_rem), 10);
    check("jam busy", int'(s_busy), 0);

    // Refill plus a fresh request clears the jam.
    ack_en = 1'b1;
    ack_dly = 1;
    exp_q.push_back(2'b10);
    done_cnt = 0;
    drive_req(10, 1'b1);
    wait_idle("post-jam");
    check("post-jam done", done_cnt, 1);
    check("post-jam error", int'(s_error), 0);
    check("post-jam err_code", int'(s_err_code), 0);
    check("post-jam remaining", int'(s_rem), 0);
    check("post-jam coins left", exp_q.size(), 0);

    // Ack on the final timeout cycle wins over the jam.
    ack_dly = AckTimeout - 1;
    exp_q.push_back(2'b01);
    done_cnt = 0;
    drive_req(5, 1'b0);
    wait_idle("late ack");
    check("late ack done", done_cnt, 1);
    check("late ack err_code", int'(s_err_code), 0);
    check("late ack coins left", exp_q.size(), 0);

    // Requests while busy are dropped.
    ack_dly = 2;
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b01);
    done_cnt = 0;
    drive_req(25, 1'b0);
    @(negedge clk);
    change_amt = 8'd5;
    change_valid = 1'b1;
    repeat (3) @(negedge clk);
    change_valid = 1'b0;
    wait_idle("busy ignore");
    repeat (4) @(negedge clk);
    check("busy ignore done", done_cnt, 1);
    check("busy ignore busy", int'(s_busy), 0);
    check("busy ignore coins left", exp_q.size(), 0);

    // Reset while a coin is pending, then a stray ack.
    ack_en = 1'b0;
    coin_ack = 1'b0;
    drive_req(20, 1'b0);
    cyc = 0;
    while (!s_coin_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("pre-reset coin_valid", int'(s_coin_valid), 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid reset coin_valid", int'(s_coin_valid), 0);
    check("mid reset remaining", int'(s_rem), 0);
    check("mid reset ready", int'(s_ready), 1);
    reset = 1'b0;
    done_cnt = 0;
    coin_ack = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
    @(negedge clk);
    check("stray ack remaining", int'(s_rem), 0);
    check("stray ack busy", int'(s_busy), 0);
    check("stray ack low_stock", int'(s_low), 0);
    check("stray ack done", done_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
